// File: rtl/game_pkg.sv
// Shared definitions for the game's on-screen blocks: screen geometry,
// bus widths and the render FSM encoding used by score_display.
package game_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOR_W  = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int GLYPH_W  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } draw_state_t;

endpackage

// File: rtl/digit_glyph_rom.sv
// 3x5 digit font. Bit index is row*3+col, col 0 being the leftmost pixel,
// so each row triple reads right-to-left in the hex constants below.
module digit_glyph_rom
  import game_pkg::*;
(
  input  logic [3:0]         i_digit,
  output logic [GLYPH_W-1:0] o_glyph
);

  always_comb begin
    o_glyph = '0;
    case (i_digit)
      4'd0:    o_glyph = 15'h7B6F;
      4'd1:    o_glyph = 15'h2492;
      4'd2:    o_glyph = 15'h73E7;
      4'd3:    o_glyph = 15'h79E7;
      4'd4:    o_glyph = 15'h49ED;
      4'd5:    o_glyph = 15'h79CF;
      4'd6:    o_glyph = 15'h7BCF;
      4'd7:    o_glyph = 15'h4927;
      4'd8:    o_glyph = 15'h7BEF;
      4'd9:    o_glyph = 15'h79EF;
      default: o_glyph = '0;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// BCD catch-score counter plus a one-pixel-per-cycle renderer that paints the
// score as 3x5 glyphs into a fixed box of the frame for vga_select.
module score_display
  import game_pkg::*;
#(
  parameter int                  X0       = 2,
  parameter int                  Y0       = 2,
  parameter int                  DIGITS   = 3,
  parameter logic [COLOR_W-1:0]  FG_COLOR = 3'b111,
  parameter logic [COLOR_W-1:0]  BG_COLOR = 3'b000
)
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  hit,
  input  logic                  draw,
  output logic [X_W-1:0]        x,
  output logic [Y_W-1:0]        y,
  output logic [COLOR_W-1:0]    color,
  output logic                  finish_drawing,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [1:0]            state_dbg
);

  localparam int             SCORE_W  = 4 * DIGITS;
  localparam int             COLS     = 4 * DIGITS;
  localparam int             COL_W    = $clog2(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [2:0]     LAST_ROW = 3'd4;

  draw_state_t        r_state;
  draw_state_t        w_state_next;
  logic [2:0]         r_row;
  logic [2:0]         w_row_next;
  logic [COL_W-1:0]   r_col;
  logic [COL_W-1:0]   w_col_next;
  logic               w_load_pix;
  logic               w_finish_next;
  logic               w_accept;

  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_inc;
  logic [SCORE_W-1:0] w_score_next;
  logic               w_all_nines;
  logic [SCORE_W-1:0] r_shown;
  logic [SCORE_W-1:0] w_pix_bcd;

  logic [COL_W-1:0]   w_digit_idx;
  logic [1:0]         w_glyph_col;
  logic [3:0]         w_digit;
  logic [3:0]         w_bit_idx;
  logic [GLYPH_W-1:0] w_glyph;
  logic [COLOR_W-1:0] w_pix_color;

  // Ripple-carry BCD increment, least significant digit first.
  always_comb begin : bcd_inc
    logic carry;
    carry       = 1'b1;
    w_all_nines = 1'b1;
    w_score_inc = r_score;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_score[4*i +: 4] != 4'd9) w_all_nines = 1'b0;
      if (carry) begin
        if (r_score[4*i +: 4] == 4'd9) begin
          w_score_inc[4*i +: 4] = 4'd0;
        end else begin
          w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
          carry                 = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_score_next = r_score;
    if (clear)                   w_score_next = '0;
    else if (hit && !w_all_nines) w_score_next = w_score_inc;
  end

  // Handshake: a pass is accepted on the edge where draw=1 in IDLE; finish_drawing
  // pulses for one cycle after the last pixel, and draw must drop before another pass.
  always_comb begin
    w_state_next  = r_state;
    w_row_next    = r_row;
    w_col_next    = r_col;
    w_load_pix    = 1'b0;
    w_finish_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (draw) begin
          w_state_next = DRAW;
          w_row_next   = 3'd0;
          w_col_next   = '0;
          w_load_pix   = 1'b1;
        end
      end
      DRAW: begin
        if (r_col == LAST_COL && r_row == LAST_ROW) begin
          w_state_next  = DONE;
          w_finish_next = 1'b1;
        end else begin
          w_load_pix = 1'b1;
          if (r_col == LAST_COL) begin
            w_col_next = '0;
            w_row_next = r_row + 3'd1;
          end else begin
            w_col_next = r_col + 1'b1;
          end
        end
      end
      DONE: begin
        if (!draw) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && draw;

  // Pixel 0 is rendered from the score being snapshotted on the same edge.
  assign w_pix_bcd   = (r_state == IDLE) ? w_score_next : r_shown;
  assign w_digit_idx = w_col_next >> 2;
  assign w_glyph_col = w_col_next[1:0];
  assign w_bit_idx   = {1'b0, w_row_next} * 4'd3 + {2'b00, w_glyph_col};

  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_digit_idx == COL_W'(i)) w_digit = w_pix_bcd[4*(DIGITS-1-i) +: 4];
    end
  end

  digit_glyph_rom u_rom (
    .i_digit (w_digit),
    .o_glyph (w_glyph)
  );

  always_comb begin
    w_pix_color = BG_COLOR;
    if (w_glyph_col != 2'd3 && w_glyph[w_bit_idx]) w_pix_color = FG_COLOR;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_score        <= '0;
      r_shown        <= '0;
      r_row          <= 3'd0;
      r_col          <= '0;
      x              <= X_W'(X0);
      y              <= Y_W'(Y0);
      color          <= BG_COLOR;
      finish_drawing <= 1'b0;
    end else begin
      r_score        <= w_score_next;
      r_row          <= w_row_next;
      r_col          <= w_col_next;
      finish_drawing <= w_finish_next;
      if (w_accept) r_shown <= w_score_next;
      if (w_load_pix) begin
        x     <= X_W'(X0) + X_W'(w_col_next);
        y     <= Y_W'(Y0) + Y_W'(w_row_next);
        color <= w_pix_color;
      end
    end
  end

  assign busy      = (r_state == DRAW);
  assign score_bcd = r_score;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: a reference font and decimal score model feed an
// expected-pixel queue that is drained while the DUT reports busy.
module tb_score_display;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        hit;
  logic        draw;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        finish_drawing;
  logic        busy;
  logic [11:0] score_bcd;
  logic [1:0]  state_dbg;

  int          n_checks = 0;
  int          n_errors = 0;
  int          model_score = 0;
  int          pass_pix = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_pix;
  logic [2:0]  fb [0:159][0:119];

  // Font rows drawn as they appear on screen: MSB is the leftmost pixel.
  logic [2:0]  font [0:9][0:4] = '{
    '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
    '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010},
    '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
    '{3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
    '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
    '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
    '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
    '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001},
    '{3'b111, 3'b101, 3'b111, 3'b101, 3'b111},
    '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111}
  };

  score_display dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .hit            (hit),
    .draw           (draw),
    .x              (x),
    .y              (y),
    .color          (color),
    .finish_drawing (finish_drawing),
    .busy           (busy),
    .score_bcd      (score_bcd),
    .state_dbg      (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic push_pass(input int v);
    for (int k = 0; k < 60; k++) begin
      int r, c, d, gc, dig;
      logic [2:0] row_bits;
      logic [2:0] pc;
      r  = k / 12;
      c  = k % 12;
      d  = c / 4;
      gc = c % 4;
      dig = (d == 0) ? v / 100 : (d == 1) ? (v / 10) % 10 : v % 10;
      row_bits = font[dig][r];
      pc = (gc != 3 && row_bits[2 - gc]) ? 3'b111 : 3'b000;
      exp_q.push_back({8'(2 + c), 7'(2 + r), pc});
    end
  endtask

  task automatic pulse_hits(input int n);
    repeat (n) begin
      @(posedge clock); #1 hit = 1'b1;
      @(posedge clock); #1 hit = 1'b0;
      if (model_score < 999) model_score++;
    end
  endtask

  // Drops draw for one edge, then requests a pass; hit_at >= 0 pulses hit
  // during that pixel cycle.
  task automatic run_pass(input int hit_at);
    int n;
    bit found;
    @(posedge clock); #1 draw = 1'b0;
    @(posedge clock); #1 draw = 1'b1;
    push_pass(model_score);
    pass_pix = 0;
    @(posedge clock);
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clock);
      n++;
      if (hit_at >= 0 && n - 1 == hit_at) begin
        hit = 1'b1;
        if (model_score < 999) model_score++;
      end else begin
        hit = 1'b0;
      end
      if (hit_at >= 0 && n - 1 == hit_at + 1)
        check("mid_hit_score", 32'(score_bcd), 32'(to_bcd(model_score)));
      if (finish_drawing === 1'b1) found = 1'b1;
    end
    hit = 1'b0;
    if (!found) begin
      check("finish_timeout", 32'(finish_drawing), 32'd1);
      exp_q.delete();
    end else begin
      check("finish_latency", 32'(n - 1), 32'd60);
    end
    check("pass_pixels", 32'(pass_pix), 32'd60);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    check("finish_width", 32'(finish_drawing), 32'd0);
    check("busy_after_pass", 32'(busy), 32'd0);
  endtask

  always @(negedge clock) begin
    if (busy === 1'b1) begin
      pass_pix++;
      if (exp_q.size() == 0) begin
        check("pix_unexpected_busy", 32'(busy), 32'd0);
      end else begin
        exp_pix = exp_q.pop_front();
        check("pixel", 32'({x, y, color}), 32'(exp_pix));
        if (x < 8'd160 && y < 7'd120) fb[x][y] = color;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fin_cnt;
    reset = 1'b1;
    clear = 1'b0;
    hit   = 1'b0;
    draw  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_score", 32'(score_bcd), 32'h000);
    check("rst_finish", 32'(finish_drawing), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_color", 32'(color), 32'd0);
    check("rst_x", 32'(x), 32'd2);
    check("rst_y", 32'(y), 32'd2);
    @(posedge clock); #1 reset = 1'b0;
    repeat (10) @(negedge clock);
    check("idle_score", 32'(score_bcd), 32'h000);
    check("idle_finish", 32'(finish_drawing), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_color", 32'(color), 32'd0);
    check("idle_xy", 32'({x, y}), 32'({8'd2, 7'd2}));

    pulse_hits(12);
    @(negedge clock);
    check("bcd_12", 32'(score_bcd), 32'h012);
    pulse_hits(88);
    @(negedge clock);
    check("bcd_100", 32'(score_bcd), 32'h100);

    @(posedge clock); #1 clear = 1'b1;
    @(posedge clock); #1 clear = 1'b0;
    model_score = 0;
    pulse_hits(1);
    @(negedge clock);
    check("bcd_001", 32'(score_bcd), 32'h001);

    run_pass(-1);
    for (int r = 0; r < 5; r++) begin
      check("one_stroke", 32'(fb[11][2 + r]), 32'd7);
      check("gap_col", 32'(fb[13][2 + r]), 32'd0);
    end
    check("one_left", 32'(fb[10][4]), 32'd0);
    check("zero_center", 32'(fb[3][4]), 32'd0);
    check("zero_corner", 32'(fb[2][2]), 32'd7);

    repeat (20) @(negedge clock);
    check("no_retrigger_busy", 32'(busy), 32'd0);
    check("held_in_done", 32'(state_dbg), 32'd2);
    run_pass(-1);

    run_pass(30);
    @(negedge clock);
    check("bcd_after_mid_hit", 32'(score_bcd), 32'h002);
    run_pass(-1);

    @(posedge clock); #1 draw = 1'b0;
    @(posedge clock); #1 draw = 1'b1;
    push_pass(model_score);
    @(posedge clock);
    repeat (21) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_finish", 32'(finish_drawing), 32'd0);
    check("midrst_score", 32'(score_bcd), 32'h000);
    check("midrst_xy", 32'({x, y}), 32'({8'd2, 7'd2}));
    check("midrst_color", 32'(color), 32'd0);
    exp_q.delete();
    model_score = 0;
    draw = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    fin_cnt = 0;
    repeat (70) begin
      @(negedge clock);
      if (finish_drawing === 1'b1) fin_cnt++;
    end
    check("no_finish_after_reset", 32'(fin_cnt), 32'd0);
    run_pass(-1);

    pulse_hits(345);
    @(negedge clock);
    check("bcd_345", 32'(score_bcd), 32'h345);
    run_pass(-1);
    pulse_hits(333);
    run_pass(-1);
    pulse_hits(321);
    @(negedge clock);
    check("bcd_999", 32'(score_bcd), 32'h999);
    run_pass(-1);
    pulse_hits(1);
    @(negedge clock);
    check("bcd_saturate", 32'(score_bcd), 32'h999);

    @(posedge clock); #1 clear = 1'b1; hit = 1'b1;
    @(posedge clock); #1 clear = 1'b0; hit = 1'b0;
    @(negedge clock);
    check("clear_priority", 32'(score_bcd), 32'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Holds the player's catch score as 3-digit BCD and renders it as 3x5-pixel glyphs in a fixed corner of the 160x120 frame.
- Emits one pixel per cycle on x/y/color; the control FSM gates these to the VGA adapter through vga_select.
- Sits directly upstream of vga_select, on the x_score/y_score/color_score inputs, and answers control's draw_score/finish_drawing_score handshake.

Parameters:
- X0, 2, left x coordinate of the score box (box spans X0..X0+4*DIGITS-1)
- Y0, 2, top y coordinate of the score box (box spans Y0..Y0+4)
- DIGITS, 3, number of decimal digits; the leftmost digit is the most significant
- FG_COLOR, 3'b111, colour of lit glyph pixels
- BG_COLOR, 3'b000, colour of unlit pixels and gap columns

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous score clear (new game)
- hit  in  1  one-cycle pulse per caught square; increments the score
- draw  in  1  level from control; high requests one render pass
- x  out  8  pixel x coordinate
- y  out  7  pixel y coordinate
- color  out  3  pixel colour
- finish_drawing  out  1  one-cycle pulse after the last pixel
- busy  out  1  high in state DRAW
- score_bcd  out  4*DIGITS  live BCD score; hundreds in [11:8]

Behaviour:
- Reset (async): score_bcd=0, state=IDLE, x=X0, y=Y0, color=BG_COLOR, finish_drawing=0, busy=0.
- Score counter:
  - clear has priority over hit; clear sets the score to 0.
  - hit performs a BCD increment with ripple carry: 0x009->0x010, 0x099->0x100.
  - Saturates at all nines (0x999); a further hit leaves it unchanged.
  - The counter updates in every state, including during a draw.
- Snapshot: on the edge that accepts draw, score_bcd (after that edge's hit/clear update) is latched into shown_bcd. The rendered digits never change mid-pass.
- FSM states:
  - IDLE: if draw=1, reset row r=0 and column c=0, latch shown_bcd, go to DRAW.
  - DRAW: advance one pixel per edge. c runs 0..4*DIGITS-1; at wrap, c returns to 0 and r increments; r runs 0..4. After the pixel (c=4*DIGITS-1, r=4) the FSM goes to DONE and finish_drawing=1 for exactly that cycle.
  - DONE: wait for draw=0, then go to IDLE. Holding draw high never retriggers a pass.
  - draw falling during DRAW is ignored; the pass completes.
- Pixel timing:
  - Outputs are registered. Pixel k (k = r*4*DIGITS + c) is on x/y/color during the k-th cycle after the accept edge, the accept cycle itself being k=0.
  - A pass is 20*DIGITS cycles (60 at default), followed by the 1-cycle finish pulse.
  - x/y/color hold their last value in DONE and IDLE.
- Pixel colour:
  - x=X0+c, y=Y0+r, digit index d=c/4 (d=0 is the leftmost digit), glyph column gc=c%4.
  - gc=3 is the inter-digit gap and is always BG_COLOR.
  - Otherwise the pixel is FG_COLOR if glyph(shown digit d)[r*3+gc]=1, else BG_COLOR.
  - Leading zeros are displayed.
- Glyphs: 15 bits, bit index = row*3+col.
  - 0=15'h7B6F, 1=15'h2492.
  - 2..9 use the standard 3x5 font.
  - Codes 10-15 give all zeros.
- Coordinate width: X0+4*DIGITS-1 must be at most 159 and Y0+4 at most 119. The arithmetic is unsigned, 8-bit for x and 7-bit for y, with no wrap.
- Reset mid-DRAW: immediate return to IDLE with reset values; no finish pulse.

Decomposition:
- Shared package game_pkg:
  - SCREEN_W=160, SCREEN_H=120, COLOR_W=3, X_W=8, Y_W=7
  - FSM state encoding: IDLE, DRAW, DONE
- Sub-module digit_glyph_rom: combinational, 4-bit digit in, 15-bit glyph out; reusable for other on-screen text.

Test Plan:
- Reset check: assert reset -> score_bcd=0x000, finish_drawing=0, busy=0, color=3'b000; release, idle 10 cycles -> all outputs unchanged.
- BCD increment: 12 hit pulses -> score_bcd=0x012; 88 more -> 0x100.
- Saturation and clear priority:
  - 999 hits -> 0x999; one more hit -> 0x999.
  - clear and hit in the same cycle -> 0x000.
- Render score 1:
  - Raise draw and hold it -> exactly 60 distinct pixels.
  - (X0+9, Y0..Y0+4) all 3'b111; (X0+8, Y0+2) and (X0+11, any row) 3'b000; digits 0 and 1 render glyph 0, e.g. (X0+1, Y0+2)=3'b000 and (X0, Y0)=3'b111.
  - finish_drawing high for 1 cycle, 60 cycles after accept.
  - Draw held high -> no second pass; drop and re-raise -> new pass.
- Mid-pass hit: hit during pixel 30 -> score_bcd updates immediately; remaining pixels still use the snapshot; the next pass shows the new value.
- Reset mid-pass: assert reset at pixel 20 -> busy=0 asynchronously, no finish pulse; a subsequent draw starts at pixel (X0, Y0).
